// File: rtl/fifo_param_sync_if.sv
// Producer/consumer bundle for fifo_param_sync: write/read requests, data, handshake
// pulses, status flags and occupancy count.
interface fifo_param_sync_if #(
    parameter int unsigned FIFO_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH = 8
);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

    logic [FIFO_WIDTH-1:0] data_in;
    logic                  wr_en;
    logic                  rd_en;
    logic [FIFO_WIDTH-1:0] data_out;
    logic                  wr_ack;
    logic                  overflow;
    logic                  underflow;
    logic                  empty;
    logic                  almostempty;
    logic                  half_full;
    logic                  almostfull;
    logic                  full;
    logic [CntW-1:0]       count;

    // Environment side: drives requests, observes everything else.
    modport master (
        output data_in, wr_en, rd_en,
        input  data_out, wr_ack, overflow, underflow,
        input  empty, almostempty, half_full, almostfull, full, count
    );

    // FIFO side.
    modport slave (
        input  data_in, wr_en, rd_en,
        output data_out, wr_ack, overflow, underflow,
        output empty, almostempty, half_full, almostfull, full, count
    );
endinterface

// File: rtl/fifo_param_sync.sv
// Parametrised single-clock FIFO with programmable almost-full/almost-empty thresholds,
// occupancy count and an optional first-word-fall-through read mode.
module fifo_param_sync #(
    parameter int unsigned FIFO_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned AF_TH      = FIFO_DEPTH - 1,
    parameter int unsigned AE_TH      = 1,
    parameter int unsigned FWFT       = 0
) (
    input logic              clk,
    input logic              rst_n,
    fifo_param_sync_if.slave bus
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

    localparam logic [PtrW-1:0] PtrLast = PtrW'(FIFO_DEPTH - 1);
    localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);
    localparam logic [CntW-1:0] CntHalf = CntW'(FIFO_DEPTH / 2);
    localparam logic [CntW-1:0] CntAf   = CntW'(AF_TH);
    localparam logic [CntW-1:0] CntAe   = CntW'(AE_TH);

    // Reject illegal configurations at elaboration.
    if (FIFO_WIDTH < 1) begin : gen_err_width
        $error("fifo_param_sync: FIFO_WIDTH must be >= 1");
    end
    if (FIFO_DEPTH < 4) begin : gen_err_depth
        $error("fifo_param_sync: FIFO_DEPTH must be >= 4");
    end
    if (AF_TH <= 1 || AF_TH >= FIFO_DEPTH) begin : gen_err_af
        $error("fifo_param_sync: AF_TH must satisfy 1 < AF_TH < FIFO_DEPTH");
    end
    if (AE_TH < 1 || AE_TH >= AF_TH) begin : gen_err_ae
        $error("fifo_param_sync: AE_TH must satisfy 1 <= AE_TH < AF_TH");
    end
    if (FWFT > 1) begin : gen_err_fwft
        $error("fifo_param_sync: FWFT must be 0 or 1");
    end

    logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]       count_q, count_d;
    logic                  wr_ack_q, wr_ack_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic empty, full, wr_acc, rd_acc;

    assign empty  = (count_q == '0);
    assign full   = (count_q == CntFull);
    // A same-cycle read never frees room for a write to a full FIFO.
    assign wr_acc = bus.wr_en && !full;
    assign rd_acc = bus.rd_en && !empty;

    // Pointer, occupancy and handshake-pulse next state.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        wr_ack_d    = wr_acc;
        overflow_d  = bus.wr_en && full;
        underflow_d = bus.rd_en && empty;
        // Explicit wrap so non-power-of-two depths work.
        if (wr_acc) begin
            wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrOne;
        end
        if (rd_acc) begin
            rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrOne;
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase
    end

    // Control state register; reset clears it without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            wr_ack_q    <= wr_ack_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array; deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= bus.data_in;
        end
    end

    if (FWFT == 0) begin : gen_reg_read
        logic [FIFO_WIDTH-1:0] data_q, data_d;

        // Output register loads the head word only on an accepted read.
        always_comb begin
            data_d = data_q;
            if (rd_acc) begin
                data_d = mem_q[rd_ptr_q];
            end
        end

        // Registered read data, cleared by reset.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_q <= '0;
            end else begin
                data_q <= data_d;
            end
        end

        assign bus.data_out = data_q;
    end else begin : gen_fwft
        // Head word shown directly; zero while empty so reset forces 0 too.
        assign bus.data_out = empty ? '0 : mem_q[rd_ptr_q];
    end

    assign bus.wr_ack      = wr_ack_q;
    assign bus.overflow    = overflow_q;
    assign bus.underflow   = underflow_q;
    assign bus.count       = count_q;
    assign bus.empty       = empty;
    assign bus.full        = full;
    assign bus.half_full   = (count_q >= CntHalf);
    assign bus.almostfull  = (count_q >= CntAf) && !full;
    assign bus.almostempty = (count_q <= CntAe) && !empty;
endmodule

// File: tb/tb_fifo_param_sync.sv
// Scoreboard bench for fifo_param_sync: three instances (depth 8 registered, depth 6
// registered with AE_TH=2, depth 4 FWFT) driven by directed vectors.
module tb_fifo_param_sync;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    fifo_param_sync_if #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) bus_a ();
    fifo_param_sync_if #(.FIFO_WIDTH(16), .FIFO_DEPTH(6)) bus_b ();
    fifo_param_sync_if #(.FIFO_WIDTH(16), .FIFO_DEPTH(4)) bus_c ();

    fifo_param_sync #(
        .FIFO_WIDTH(16), .FIFO_DEPTH(8), .AF_TH(7), .AE_TH(1), .FWFT(0)
    ) u_a (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_a)
    );

    fifo_param_sync #(
        .FIFO_WIDTH(16), .FIFO_DEPTH(6), .AF_TH(5), .AE_TH(2), .FWFT(0)
    ) u_b (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_b)
    );

    fifo_param_sync #(
        .FIFO_WIDTH(16), .FIFO_DEPTH(4), .AF_TH(3), .AE_TH(1), .FWFT(1)
    ) u_c (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_c)
    );

    typedef struct {
        int          cyc;
        int          dut;
        logic        ack;
        logic        ovf;
        logic        unf;
        int          cnt;
        logic [15:0] dout;
        logic [4:0]  fl;
        string       tag;
    } exp_t;

    exp_t exp_q[$];

    // Hand-computed {empty, almostempty, half_full, almostfull, full} per instance/count.
    function automatic logic [4:0] flags_of(input int d, input int c);
        case (d)
            0: case (c)
                0: return 5'b10000;
                1: return 5'b01000;
                2, 3: return 5'b00000;
                4, 5, 6: return 5'b00100;
                7: return 5'b00110;
                8: return 5'b00101;
                default: return 5'b00000;
            endcase
            1: case (c)
                0: return 5'b10000;
                1, 2: return 5'b01000;
                3, 4: return 5'b00100;
                5: return 5'b00110;
                6: return 5'b00101;
                default: return 5'b00000;
            endcase
            default: case (c)
                0: return 5'b10000;
                1: return 5'b01000;
                2: return 5'b00100;
                3: return 5'b00110;
                4: return 5'b00101;
                default: return 5'b00000;
            endcase
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic idle_all();
        bus_a.wr_en = 1'b0; bus_a.rd_en = 1'b0; bus_a.data_in = '0;
        bus_b.wr_en = 1'b0; bus_b.rd_en = 1'b0; bus_b.data_in = '0;
        bus_c.wr_en = 1'b0; bus_c.rd_en = 1'b0; bus_c.data_in = '0;
    endtask

    // Drive one cycle on instance d and queue the outcome expected after the next edge.
    task automatic step(input int d, input logic wr, input logic rd, input logic [15:0] din,
                        input logic ack, input logic ovf, input logic unf, input int cnt,
                        input logic [15:0] dout, input string tag);
        exp_t e;
        idle_all();
        case (d)
            0: begin bus_a.wr_en = wr; bus_a.rd_en = rd; bus_a.data_in = din; end
            1: begin bus_b.wr_en = wr; bus_b.rd_en = rd; bus_b.data_in = din; end
            default: begin bus_c.wr_en = wr; bus_c.rd_en = rd; bus_c.data_in = din; end
        endcase
        e.cyc  = cyc + 1;
        e.dut  = d;
        e.ack  = ack;
        e.ovf  = ovf;
        e.unf  = unf;
        e.cnt  = cnt;
        e.dout = dout;
        e.fl   = flags_of(d, cnt);
        e.tag  = tag;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "/a_state"}, 32'({bus_a.wr_ack, bus_a.overflow, bus_a.underflow, bus_a.empty,
            bus_a.almostempty, bus_a.half_full, bus_a.almostfull, bus_a.full}), 32'h10);
        chk({tag, "/a_count"}, 32'(bus_a.count), 0);
        chk({tag, "/a_data"}, 32'(bus_a.data_out), 0);
        chk({tag, "/b_state"}, 32'({bus_b.wr_ack, bus_b.overflow, bus_b.underflow, bus_b.empty,
            bus_b.almostempty, bus_b.half_full, bus_b.almostfull, bus_b.full}), 32'h10);
        chk({tag, "/b_data"}, 32'(bus_b.data_out), 0);
        chk({tag, "/c_state"}, 32'({bus_c.wr_ack, bus_c.overflow, bus_c.underflow, bus_c.empty,
            bus_c.almostempty, bus_c.half_full, bus_c.almostfull, bus_c.full}), 32'h10);
        chk({tag, "/c_data"}, 32'(bus_c.data_out), 0);
    endtask

    // Monitor: pops expectations due at this cycle and compares against the instance.
    exp_t        m;
    logic        a_ack, a_ovf, a_unf;
    logic [31:0] a_cnt, a_dout;
    logic [4:0]  a_fl;
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            m = exp_q.pop_front();
            case (m.dut)
                0: begin
                    a_ack = bus_a.wr_ack; a_ovf = bus_a.overflow; a_unf = bus_a.underflow;
                    a_cnt = 32'(bus_a.count); a_dout = 32'(bus_a.data_out);
                    a_fl = {bus_a.empty, bus_a.almostempty, bus_a.half_full,
                            bus_a.almostfull, bus_a.full};
                end
                1: begin
                    a_ack = bus_b.wr_ack; a_ovf = bus_b.overflow; a_unf = bus_b.underflow;
                    a_cnt = 32'(bus_b.count); a_dout = 32'(bus_b.data_out);
                    a_fl = {bus_b.empty, bus_b.almostempty, bus_b.half_full,
                            bus_b.almostfull, bus_b.full};
                end
                default: begin
                    a_ack = bus_c.wr_ack; a_ovf = bus_c.overflow; a_unf = bus_c.underflow;
                    a_cnt = 32'(bus_c.count); a_dout = 32'(bus_c.data_out);
                    a_fl = {bus_c.empty, bus_c.almostempty, bus_c.half_full,
                            bus_c.almostfull, bus_c.full};
                end
            endcase
            chk({m.tag, "/sched"}, cyc, m.cyc);
            chk({m.tag, "/pulses"}, 32'({a_ack, a_ovf, a_unf}), 32'({m.ack, m.ovf, m.unf}));
            chk({m.tag, "/count"}, a_cnt, m.cnt);
            chk({m.tag, "/flags"}, 32'(a_fl), 32'(m.fl));
            chk({m.tag, "/data_out"}, a_dout, 32'(m.dout));
        end
    end

    initial begin
        idle_all();
        #2 rst_n = 1'b0;
        #1 chk_reset("init_rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Depth 8: fill to full plus one rejected write.
        for (int i = 1; i <= 9; i++)
            step(0, 1'b1, 1'b0, 16'(i), i <= 8, i == 9, 1'b0, (i <= 8) ? i : 8, 16'h0000,
                 $sformatf("fill%0d", i));
        // Drain in order plus one rejected read; data held after the failed read.
        for (int i = 1; i <= 9; i++)
            step(0, 1'b0, 1'b1, 16'h0, 1'b0, 1'b0, i == 9, (i <= 8) ? 8 - i : 0,
                 (i <= 8) ? 16'(i) : 16'h0008, $sformatf("drain%0d", i));
        // Simultaneous access at empty, mid-level and full.
        step(0, 1'b1, 1'b1, 16'h00E0, 1'b1, 1'b0, 1'b1, 1, 16'h0008, "sim_empty");
        for (int i = 1; i <= 3; i++)
            step(0, 1'b1, 1'b0, 16'(16'h00E0 + i), 1'b1, 1'b0, 1'b0, 1 + i, 16'h0008,
                 $sformatf("up%0d", i));
        step(0, 1'b1, 1'b1, 16'h00E4, 1'b1, 1'b0, 1'b0, 4, 16'h00E0, "sim_mid");
        for (int i = 1; i <= 4; i++)
            step(0, 1'b1, 1'b0, 16'(16'h00E4 + i), 1'b1, 1'b0, 1'b0, 4 + i, 16'h00E0,
                 $sformatf("up_full%0d", i));
        step(0, 1'b1, 1'b1, 16'h00FF, 1'b0, 1'b1, 1'b0, 7, 16'h00E1, "sim_full");
        for (int i = 1; i <= 7; i++)
            step(0, 1'b0, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 7 - i, 16'(16'h00E1 + i),
                 $sformatf("drain_e%0d", i));

        // Asynchronous reset with 5 entries held and a wr_ack pulse showing.
        for (int i = 1; i <= 5; i++)
            step(0, 1'b1, 1'b0, 16'(16'h0010 + i), 1'b1, 1'b0, 1'b0, i, 16'h00E8,
                 $sformatf("pre%0d", i));
        step(0, 1'b1, 1'b1, 16'h0016, 1'b1, 1'b0, 1'b0, 5, 16'h0011, "pre_rst");
        idle_all();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset("mid_rst");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(0, 1'b0, 1'b1, 16'h0, 1'b0, 1'b0, 1'b1, 0, 16'h0000, "post_rst_rd");

        // Depth 6: pointers wrap three times while three words stay resident.
        for (int n = 1; n <= 3; n++)
            step(1, 1'b1, 1'b0, 16'(16'h0100 + n), 1'b1, 1'b0, 1'b0, n, 16'h0000,
                 $sformatf("wrap_w%0d", n));
        for (int j = 1; j <= 18; j++)
            step(1, 1'b1, 1'b1, 16'(16'h0103 + j), 1'b1, 1'b0, 1'b0, 3, 16'(16'h0100 + j),
                 $sformatf("wrap_rw%0d", j));
        for (int j = 19; j <= 21; j++)
            step(1, 1'b0, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 21 - j, 16'(16'h0100 + j),
                 $sformatf("wrap_r%0d", j));
        for (int n = 1; n <= 7; n++)
            step(1, 1'b1, 1'b0, 16'(16'h0200 + n), n <= 6, n == 7, 1'b0, (n <= 6) ? n : 6,
                 16'h0115, $sformatf("b_fill%0d", n));
        for (int n = 1; n <= 6; n++)
            step(1, 1'b0, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 6 - n, 16'(16'h0200 + n),
                 $sformatf("b_drain%0d", n));

        // Depth 4 FWFT: head visible without a read request.
        step(2, 1'b1, 1'b0, 16'hA5A5, 1'b1, 1'b0, 1'b0, 1, 16'hA5A5, "fwft_w1");
        step(2, 1'b1, 1'b0, 16'h5A5A, 1'b1, 1'b0, 1'b0, 2, 16'hA5A5, "fwft_w2");
        step(2, 1'b0, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 1, 16'h5A5A, "fwft_r1");
        step(2, 1'b0, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 0, 16'h0000, "fwft_r2");
        step(2, 1'b0, 1'b1, 16'h0, 1'b0, 1'b0, 1'b1, 0, 16'h0000, "fwft_unf");
        step(2, 1'b1, 1'b1, 16'h1234, 1'b1, 1'b0, 1'b1, 1, 16'h1234, "fwft_sim");
        for (int i = 1; i <= 3; i++)
            step(2, 1'b1, 1'b0, 16'(16'h0C00 + i), 1'b1, 1'b0, 1'b0, 1 + i, 16'h1234,
                 $sformatf("fwft_fill%0d", i));
        step(2, 1'b1, 1'b0, 16'hDEAD, 1'b0, 1'b1, 1'b0, 4, 16'h1234, "fwft_ovf");

        idle_all();
        repeat (3) @(posedge clk);
        #1;
        if (exp_q.size() != 0) chk("leftover", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
